// File: rtl/readout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : readout_pkg
// Brief    : Shared state encoding for the packed array readout sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package readout_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage : readout_pkg
`default_nettype wire

// File: rtl/packed_readout_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : packed_readout_seq_if
// Brief    : Valid/ready element stream carrying data, index and last flag.
// Revision : 1.0 - initial release
// ============================================================================
interface packed_readout_seq_if #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 3
) ();

    logic [WIDTH-1:0] m_data;
    logic [IDXW-1:0]  m_idx;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (
        output m_data,
        output m_idx,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_idx,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface : packed_readout_seq_if
`default_nettype wire

// File: rtl/packed_elem_mux.sv
`default_nettype none
// ============================================================================
// Module   : packed_elem_mux
// Brief    : Combinational selector of one WIDTH-bit element from a packed array.
// Revision : 1.0 - initial release
// ============================================================================
module packed_elem_mux #(
    parameter int WIDTH = 16,
    parameter int LEN   = 8
) (
    input  wire logic [WIDTH*LEN-1:0]   data_packed,
    input  wire logic [$clog2(LEN)-1:0] idx,
    output logic      [WIDTH-1:0]       word
);

    localparam int IDXW = $clog2(LEN);

    logic [WIDTH-1:0] w_elems [LEN];

    for (genvar i = 0; i < LEN; i++) begin : g_elem
        assign w_elems[i] = data_packed[WIDTH*i +: WIDTH];
    end

    // Compare-and-select keeps out-of-range indices (non power-of-two LEN) at zero.
    always_comb begin
        word = '0;
        for (int i = 0; i < LEN; i++) begin
            if (idx == IDXW'(i)) begin
                word = w_elems[i];
            end
        end
    end

endmodule : packed_elem_mux
`default_nettype wire

// File: rtl/packed_readout_seq.sv
`default_nettype none
// ============================================================================
// Module   : packed_readout_seq
// Brief    : Snapshots a packed array and streams its elements out in order.
// Revision : 1.0 - initial release
// ============================================================================
module packed_readout_seq
    import readout_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN   = 8,
    parameter int IDXW  = $clog2(LEN)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 start,
    input  wire logic                 abort,
    input  wire logic [WIDTH*LEN-1:0] data_packed,
    output logic                      busy,
    output logic                      done,
    packed_readout_seq_if.master      m
);

    localparam logic [IDXW-1:0] c_last_idx = IDXW'(LEN - 1);

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_valid;
    logic                 r_last;
    logic [IDXW-1:0]      r_idx;
    logic [WIDTH*LEN-1:0] r_snapshot;

    logic [IDXW-1:0]      w_idx_next;
    logic [WIDTH-1:0]     w_word;

    assign w_idx_next = r_idx + IDXW'(1);

    packed_elem_mux #(
        .WIDTH (WIDTH),
        .LEN   (LEN)
    ) u_elem_mux (
        .data_packed (r_snapshot),
        .idx         (r_idx),
        .word        (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_idx      <= '0;
            r_snapshot <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_state <= CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_snapshot <= data_packed;
                        r_idx      <= '0;
                        r_last     <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        // An accepted final element still counts, but no done follows.
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end else if (m.m_ready) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx  <= w_idx_next;
                            r_last <= (w_idx_next == c_last_idx);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign m.m_data  = w_word;
    assign m.m_idx   = r_idx;
    assign m.m_valid = r_valid;
    assign m.m_last  = r_last;

endmodule : packed_readout_seq
`default_nettype wire

// File: tb/tb_packed_readout_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_packed_readout_seq
// Brief    : Directed self-checking bench for packed_readout_seq (WIDTH=16, LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packed_readout_seq;

    localparam int WIDTH = 16;
    localparam int LEN   = 4;
    localparam int IDXW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [WIDTH*LEN-1:0] data_packed = '0;
    logic                 busy;
    logic                 done;

    int n_total = 0;
    int n_bad   = 0;

    logic [WIDTH-1:0] exp_w [LEN];

    packed_readout_seq_if #(.WIDTH(WIDTH), .IDXW(IDXW)) m_if ();

    packed_readout_seq #(
        .WIDTH (WIDTH),
        .LEN   (LEN),
        .IDXW  (IDXW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .data_packed (data_packed),
        .busy        (busy),
        .done        (done),
        .m           (m_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full pass; the stream is checked against exp_w every cycle m_valid is expected.
    task automatic run_pass(input logic [63:0] d, input bit toggle_ready,
                            input bit corrupt, input bit start_mid);
        int k;
        int idx_exp;
        data_packed   = d;
        m_if.m_ready  = 1'b1;
        start         = 1'b1;
        tick();
        start = 1'b0;
        check_eq("cap_busy", 64'(busy), 64'd1);
        check_eq("cap_valid", 64'(m_if.m_valid), 64'd0);
        tick();
        if (corrupt) data_packed = '1;
        idx_exp = 0;
        k       = 0;
        while (idx_exp < LEN && k < 40) begin
            m_if.m_ready = toggle_ready ? (k % 3 == 0) : 1'b1;
            start        = start_mid && (k == 1);
            check_eq("s_valid", 64'(m_if.m_valid), 64'd1);
            check_eq("s_data", 64'(m_if.m_data), 64'(exp_w[idx_exp]));
            check_eq("s_idx", 64'(m_if.m_idx), 64'(idx_exp));
            check_eq("s_last", 64'(m_if.m_last), 64'(idx_exp == LEN - 1));
            check_eq("s_done", 64'(done), 64'd0);
            if (m_if.m_ready) idx_exp++;
            k++;
            tick();
        end
        start        = 1'b0;
        m_if.m_ready = 1'b1;
        check_eq("pass_count", 64'(idx_exp), 64'(LEN));
        check_eq("end_done", 64'(done), 64'd1);
        check_eq("end_valid", 64'(m_if.m_valid), 64'd0);
        check_eq("end_busy", 64'(busy), 64'd1);
        tick();
        check_eq("idle_done", 64'(done), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);
        tick();
        tick();
        check_eq("no_requeue", 64'(busy), 64'd0);
    endtask

    initial begin
        m_if.m_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_valid", 64'(m_if.m_valid), 64'd0);
        check_eq("rst_last", 64'(m_if.m_last), 64'd0);
        check_eq("rst_idx", 64'(m_if.m_idx), 64'd0);
        check_eq("rst_data", 64'(m_if.m_data), 64'd0);
        rst = 1'b0;

        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
        run_pass(64'h4444_3333_2222_1111, 1'b0, 1'b0, 1'b0);
        run_pass(64'h4444_3333_2222_1111, 1'b1, 1'b0, 1'b0);
        run_pass(64'h4444_3333_2222_1111, 1'b0, 1'b1, 1'b0);
        run_pass(64'h4444_3333_2222_1111, 1'b0, 1'b0, 1'b1);

        // Abort in the middle of a pass, then replay from index 0.
        exp_w[0] = 16'hA5A5; exp_w[1] = 16'h0F0F; exp_w[2] = 16'hBEEF; exp_w[3] = 16'hDEAD;
        data_packed = 64'hDEAD_BEEF_0F0F_A5A5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("ab_idx", 64'(m_if.m_idx), 64'd2);
        check_eq("ab_data", 64'(m_if.m_data), 64'h0000_0000_0000_BEEF);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("ab_valid", 64'(m_if.m_valid), 64'd0);
        check_eq("ab_busy", 64'(busy), 64'd0);
        check_eq("ab_done", 64'(done), 64'd0);
        tick();
        check_eq("ab_done2", 64'(done), 64'd0);
        run_pass(64'hDEAD_BEEF_0F0F_A5A5, 1'b0, 1'b0, 1'b0);

        // start together with abort in IDLE does nothing.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("sa_busy", 64'(busy), 64'd0);
        check_eq("sa_valid", 64'(m_if.m_valid), 64'd0);
        tick();
        check_eq("sa_busy2", 64'(busy), 64'd0);

        // Abort coinciding with the final transfer.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check_eq("af_idx", 64'(m_if.m_idx), 64'd3);
        check_eq("af_last", 64'(m_if.m_last), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("af_valid", 64'(m_if.m_valid), 64'd0);
        check_eq("af_busy", 64'(busy), 64'd0);
        check_eq("af_done", 64'(done), 64'd0);
        tick();
        check_eq("af_done2", 64'(done), 64'd0);

        // Asynchronous reset mid-SEND.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("mr_pre_idx", 64'(m_if.m_idx), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("mr_busy", 64'(busy), 64'd0);
        check_eq("mr_valid", 64'(m_if.m_valid), 64'd0);
        check_eq("mr_last", 64'(m_if.m_last), 64'd0);
        check_eq("mr_idx", 64'(m_if.m_idx), 64'd0);
        check_eq("mr_data", 64'(m_if.m_data), 64'd0);
        check_eq("mr_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("mr_done2", 64'(done), 64'd0);
        check_eq("mr_busy2", 64'(busy), 64'd0);
        run_pass(64'hDEAD_BEEF_0F0F_A5A5, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_packed_readout_seq
`default_nettype wire

// File: doc/packed_readout_seq.md
PACKED_READOUT_SEQ -- requirements
Module: packed_readout_seq

Interface
REQ-001 Parameter WIDTH, default 16, bits per array element.
REQ-002 Parameter LEN, default 8, number of elements in the array; legal range 2..256.
REQ-003 Parameter IDXW, default $clog2(LEN), width of the element index.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port clk  in  1  sole clock; all state rising-edge.
REQ-006 Port rst  in  1  asynchronous active-high reset.
REQ-007 Port start  in  1  request one readout pass; sampled in IDLE only.
REQ-008 Port abort  in  1  terminate the current pass.
REQ-009 Port data_packed  in  WIDTH*LEN  packed array; element i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-010 Port busy  out  1  high in every state except IDLE.
REQ-011 Port done  out  1  one-cycle pulse when a pass completes without abort.
REQ-012 Port m_data  out  WIDTH  current element.
REQ-013 Port m_idx  out  IDXW  index of m_data.
REQ-014 Port m_valid  out  1  m_data/m_idx valid.
REQ-015 Port m_ready  in  1  consumer accepts; a transfer occurs when m_valid && m_ready.
REQ-016 Port m_last  out  1  high with m_valid when m_idx == LEN-1.

Function
REQ-017 The FSM SHALL have the states IDLE, CAPTURE, SEND and DONE.
REQ-018 In IDLE, start=1 with abort=0 SHALL move the FSM to CAPTURE on the next edge.
REQ-019 In CAPTURE, the block SHALL latch all of data_packed into an internal snapshot, clear the index to 0, and move to SEND.
  - Latency: start to first m_valid is exactly 2 cycles.
REQ-020 In SEND, m_valid SHALL be 1, m_data SHALL equal snapshot element m_idx, and changes to data_packed after capture SHALL have no effect.
REQ-021 While m_valid=1 and m_ready=0, m_data, m_idx and m_last SHALL hold stable.
REQ-022 On a transfer with m_idx < LEN-1, m_idx SHALL increment by 1, with no bubble cycle between elements.
REQ-023 On a transfer with m_idx == LEN-1, the FSM SHALL go to DONE; in DONE, m_valid=0 and done=1 for one cycle, then the FSM returns to IDLE.
REQ-024 start asserted in any state other than IDLE SHALL be ignored; it is not queued.
REQ-025 abort=1 in CAPTURE, SEND or DONE SHALL force IDLE on the next edge.
  - m_valid drops that edge.
  - done is not pulsed; a same-cycle DONE pulse is still emitted.
  - Snapshot contents are don't-care.
REQ-026 When abort and a final transfer occur in the same SEND cycle, the transfer SHALL count, the FSM SHALL enter IDLE, and done SHALL not pulse.
REQ-027 When start and abort are both 1 in IDLE, the FSM SHALL stay in IDLE.
REQ-028 The index SHALL never exceed LEN-1; there is no wrap-around within a pass.
REQ-029 Throughput SHALL be one element per cycle when m_ready is held at 1, giving a pass of LEN+3 cycles from start to IDLE.

Reset
REQ-030 While rst is asserted, the block SHALL be in IDLE with the following values:
  - busy=0, done=0, m_valid=0, m_last=0.
  - m_idx=0, m_data=0, snapshot=0.
REQ-031 Reset asserted mid-pass SHALL abandon the pass immediately (asynchronously), and no done SHALL follow.
REQ-032 After rst deasserts, the first start SHALL be accepted on the first clock edge.

Structure
REQ-033 The state encoding typedef and the state constants SHALL reside in the shared package readout_pkg.
REQ-034 Element selection SHALL be a sub-module packed_elem_mux (parameters WIDTH, LEN; inputs data_packed and idx; output word), purely combinational.
REQ-035 The snapshot SHALL be a single WIDTH*LEN register using the same bit layout as data_packed.

Verification
REQ-036 WIDTH=16, LEN=4, data_packed=64'h4444_3333_2222_1111, m_ready=1, start pulse -> m_data 1111, 2222, 3333, 4444 on consecutive cycles starting 2 cycles after start; m_last only with 4444; done 1 cycle later.
REQ-037 Same pass with m_ready toggling 1,0,0,1,... -> every element delivered exactly once in order; m_data stable during stalls.
REQ-038 data_packed changed to all-ones 1 cycle after capture -> outputs remain 1111..4444.
REQ-039 abort asserted while m_idx=2 -> m_valid=0 next cycle, busy=0, no done; next start replays from index 0.
REQ-040 start pulsed during SEND -> ignored; exactly one pass and one done pulse.
REQ-041 rst asserted mid-SEND, then released, then start -> all outputs at reset values immediately; new pass completes normally.
